// File: rtl/hyper_eot_tracker_if.sv
// rtl/hyper_eot_tracker_if.sv - launch/eot request and completion event bundle for hyper_eot_tracker
//
// Ports (master = launching side, slave = tracker):
//   clr        master->slave  NB_CH        per-channel synchronous flush
//   launch_rx  master->slave  NB_CH        RX transfer launched
//   launch_tx  master->slave  NB_CH        TX transfer launched
//   eot        master->slave  NB_CH        controller finished oldest transfer
//   evt_rx_eot slave->master  NB_CH        RX transfer completed, 1-cycle pulse
//   evt_tx_eot slave->master  NB_CH        TX transfer completed, 1-cycle pulse
//   pending    slave->master  NB_CH*CNT_W  per-channel occupancy, channel c at [c*CNT_W +: CNT_W]
//   ovf        slave->master  NB_CH        sticky: launch dropped on full FIFO
//   udf        slave->master  NB_CH        sticky: eot with empty FIFO
interface hyper_eot_tracker_if #(
    parameter int NB_CH = 2,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
);
    logic [NB_CH-1:0]       clr;
    logic [NB_CH-1:0]       launch_rx;
    logic [NB_CH-1:0]       launch_tx;
    logic [NB_CH-1:0]       eot;
    logic [NB_CH-1:0]       evt_rx_eot;
    logic [NB_CH-1:0]       evt_tx_eot;
    logic [NB_CH*CNT_W-1:0] pending;
    logic [NB_CH-1:0]       ovf;
    logic [NB_CH-1:0]       udf;

    modport master (
        output clr, launch_rx, launch_tx, eot,
        input  evt_rx_eot, evt_tx_eot, pending, ovf, udf
    );

    modport slave (
        input  clr, launch_rx, launch_tx, eot,
        output evt_rx_eot, evt_tx_eot, pending, ovf, udf
    );
endinterface

// File: rtl/hyper_eot_tracker.sv
// rtl/hyper_eot_tracker.sv - per-channel in-order RX/TX tag FIFO routing eot pulses to rx/tx done events
//
// Ports:
//   sys_clk_i  in   clock, rising edge
//   rstn_i     in   asynchronous active-low reset
//   bus        slave modport of hyper_eot_tracker_if (flush/launch/eot in; events, occupancy, sticky flags out)
//
// Each channel holds a shift-register of direction tags (1 = RX, 0 = TX) with the
// oldest tag at bit 0. A pop shifts right; new tags are written just above the
// surviving entries, so order is preserved without read/write pointers.
module hyper_eot_tracker #(
    parameter int NB_CH = 2,
    parameter int DEPTH = 4
) (
    input  logic                  sys_clk_i,
    input  logic                  rstn_i,
    hyper_eot_tracker_if.slave    bus
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    for (genvar c = 0; c < NB_CH; c++) begin : g_ch
        logic [DEPTH-1:0] tags_q, tags_n;
        logic [CNT_W-1:0] count_q, count_n;
        logic             evt_rx_q, evt_tx_q, ovf_q, udf_q;
        logic             evt_rx_n, evt_tx_n, ovf_n, udf_n;
        logic             clr, rx, tx, eot, pop, accept;
        logic [CNT_W:0]   count_w, npush, avail, base;

        assign clr = bus.clr[c];
        assign rx  = bus.launch_rx[c];
        assign tx  = bus.launch_tx[c];
        assign eot = bus.eot[c];

        always_comb begin
            count_w = {1'b0, count_q};
            // Pop only ever looks at the head present at the start of the cycle,
            // so a same-cycle push can never be consumed.
            pop     = eot && (count_q != '0);
            npush   = (CNT_W+1)'(rx) + (CNT_W+1)'(tx);
            avail   = (CNT_W+1)'(DEPTH) - count_w + (CNT_W+1)'(pop);
            // All-or-nothing: a dual launch that does not fully fit is dropped whole.
            accept  = (npush != '0) && (npush <= avail);
            base    = count_w - (CNT_W+1)'(pop);

            tags_n = pop ? (tags_q >> 1) : tags_q;
            for (int i = 0; i < DEPTH; i++) begin
                // First slot takes RX if launched, else the lone TX; a dual launch
                // puts its TX tag in the next slot up.
                if (accept && ((CNT_W+1)'(i) == base)) begin
                    tags_n[i] = rx;
                end
                if (accept && rx && tx && ((CNT_W+1)'(i) == base + (CNT_W+1)'(1))) begin
                    tags_n[i] = 1'b0;
                end
            end

            count_n  = CNT_W'(base + (accept ? npush : '0));
            evt_rx_n = pop & tags_q[0];
            evt_tx_n = pop & ~tags_q[0];
            ovf_n    = ovf_q | ((npush != '0) && !accept);
            udf_n    = udf_q | (eot && (count_q == '0));

            if (clr) begin
                tags_n   = tags_q;
                count_n  = '0;
                evt_rx_n = 1'b0;
                evt_tx_n = 1'b0;
                ovf_n    = 1'b0;
                udf_n    = 1'b0;
            end
        end

        always_ff @(posedge sys_clk_i or negedge rstn_i) begin
            if (!rstn_i) begin
                tags_q   <= '0;
                count_q  <= '0;
                evt_rx_q <= 1'b0;
                evt_tx_q <= 1'b0;
                ovf_q    <= 1'b0;
                udf_q    <= 1'b0;
            end else begin
                tags_q   <= tags_n;
                count_q  <= count_n;
                evt_rx_q <= evt_rx_n;
                evt_tx_q <= evt_tx_n;
                ovf_q    <= ovf_n;
                udf_q    <= udf_n;
            end
        end

        assign bus.evt_rx_eot[c]               = evt_rx_q;
        assign bus.evt_tx_eot[c]               = evt_tx_q;
        assign bus.pending[c*CNT_W +: CNT_W]   = count_q;
        assign bus.ovf[c]                      = ovf_q;
        assign bus.udf[c]                      = udf_q;
    end
endmodule
